regfile_wb_arb: RTL and testbench

Write-back arbiter and scoreboard for the three-ported 32x32 register file. Two result producers share the single write port: requester 0 is the ALU/load path, requester 1 is a multicycle unit such as a multiply/divide. The block arbitrates between them with valid/ready handshakes and registers the winning write onto the file's `we3`/`wa3`/`wd3`. It also keeps a per-register busy scoreboard, so the issue logic can stall on pending destinations.

---
 rtl/mips_pkg.sv | 12 +
 rtl/rr_arb2.sv | 36 +++
 rtl/regfile_wb_arb.sv | 105 ++++++++++
 tb/tb_regfile_wb_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: word/address widths, register count
// and the write-back requester identifiers.
package mips_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MC  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. prio names the requester that wins a tie;
// after any grant it moves to the requester that was not granted.
module rr_arb2
  import mips_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic prio_reg;
  logic prio_next;

  always_comb begin
    grant0    = valid0 && (!valid1 || prio_reg == REQ_ALU);
    grant1    = valid1 && (!valid0 || prio_reg == REQ_MC);
    prio_next = prio_reg;
    if (grant0) begin
      prio_next = REQ_MC;
    end else if (grant1) begin
      prio_next = REQ_ALU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_reg <= REQ_ALU;
    end else begin
      prio_reg <= prio_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Write-back arbiter for the register file write port plus a per-register
// busy scoreboard used by issue/decode to stall on pending destinations.
module regfile_wb_arb #(
  parameter int DW = mips_pkg::DW,
  parameter int AW = mips_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  input  logic [AW-1:0] chk_a1,
  input  logic [AW-1:0] chk_a2,
  output logic          busy1,
  output logic          busy2,
  output logic          err
);

  localparam int NR = 1 << AW;

  logic          grant0;
  logic          grant1;
  logic          handshake;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [NR-1:0] sb_reg;
  logic [NR-1:0] sb_next;
  logic          rsv_illegal;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign handshake  = grant0 | grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;

  // r0 writes are accepted to free the requester but never reach the file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (handshake) begin
      we3 <= (sel_addr != '0);
      wa3 <= sel_addr;
      wd3 <= sel_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  assign sb_next[0] = 1'b0;

  // A reservation landing on the commit edge belongs to a newer instruction,
  // so set takes precedence over clear.
  generate
    for (genvar gi = 1; gi < NR; gi++) begin : g_sb
      always_comb begin
        sb_next[gi] = sb_reg[gi];
        if (rsv_valid && rsv_addr == AW'(gi)) begin
          sb_next[gi] = 1'b1;
        end else if (we3 && wa3 == AW'(gi)) begin
          sb_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  assign rsv_illegal = rsv_valid && (rsv_addr != '0) && sb_reg[rsv_addr]
                       && !(we3 && wa3 == rsv_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_reg <= '0;
      err    <= 1'b0;
    end else begin
      sb_reg <= sb_next;
      if (rsv_illegal) begin
        err <= 1'b1;
      end
    end
  end

  assign busy1 = sb_reg[chk_a1];
  assign busy2 = sb_reg[chk_a2];

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: a behavioural model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_regfile_wb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [4:0]  chk_a1, chk_a2;
  logic        busy1, busy2;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wb_arb #(.DW(32), .AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .chk_a1     (chk_a1),
    .chk_a2     (chk_a2),
    .busy1      (busy1),
    .busy2      (busy2),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tie winner, pending write-port contents, busy set, sticky error.
  logic        m_prio;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_sb;
  logic        m_err;
  logic [1:0]  m_grant;

  function automatic logic [1:0] winner(input logic v0, input logic v1, input logic p);
    if (v0 && v1) return p ? 2'b10 : 2'b01;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  assign m_grant = winner(req0_valid, req1_valid, m_prio);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prio <= 1'b0;
      m_we   <= 1'b0;
      m_wa   <= '0;
      m_wd   <= '0;
      m_sb   <= '0;
      m_err  <= 1'b0;
    end else begin
      if (m_grant != 2'b00) begin
        m_prio <= m_grant[0];
        m_wa   <= m_grant[1] ? req1_addr : req0_addr;
        m_wd   <= m_grant[1] ? req1_data : req0_data;
        m_we   <= (m_grant[1] ? req1_addr : req0_addr) != 5'd0;
      end else begin
        m_we <= 1'b0;
      end
      m_sb <= ((m_sb & ~((m_we ? 32'd1 : 32'd0) << m_wa))
               | ((rsv_valid ? 32'd1 : 32'd0) << rsv_addr)) & ~32'd1;
      if (rsv_valid && rsv_addr != 0 && m_sb[rsv_addr] && !(m_we && m_wa == rsv_addr))
        m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, m_grant[0]});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, m_grant[1]});
    chk("we3", {31'd0, we3}, {31'd0, m_we});
    chk("wa3", {27'd0, wa3}, {27'd0, m_wa});
    chk("wd3", wd3, m_wd);
    chk("busy1", {31'd0, busy1}, {31'd0, m_sb[chk_a1]});
    chk("busy2", {31'd0, busy2}, {31'd0, m_sb[chk_a2]});
    chk("err", {31'd0, err}, {31'd0, m_err});
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int a0[4]   = '{1, 2, 2, 3};
  int a1[4]   = '{8, 8, 9, 9};
  int gexp[4] = '{0, 1, 0, 1};
  int wexp[4] = '{1, 8, 2, 9};

  initial begin
    reset = 1'b1;
    rsv_valid = 0; rsv_addr = 0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    chk_a1 = 0; chk_a2 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_we3", {31'd0, we3}, 32'd0);
    chk("reset_busy1", {31'd0, busy1}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    nxt();

    // Reserve r5, commit it three cycles later.
    rsv_valid = 1; rsv_addr = 5; chk_a1 = 5; chk_a2 = 5;
    nxt(); rsv_valid = 0; #1 chk("r5_busy_c1", {31'd0, busy1}, 32'd1);
    nxt(); #1 chk("r5_busy_c2", {31'd0, busy1}, 32'd1);
    nxt(); req0_valid = 1; req0_addr = 5; req0_data = 32'h1234;
    #1 chk("r5_busy_c3", {31'd0, busy1}, 32'd1);
    chk("r5_ready", {31'd0, req0_ready}, 32'd1);
    nxt(); req0_valid = 0; #1;
    chk("r5_we3", {31'd0, we3}, 32'd1);
    chk("r5_wa3", {27'd0, wa3}, 32'd5);
    chk("r5_wd3", wd3, 32'h1234);
    chk("r5_busy_c4", {31'd0, busy1}, 32'd1);
    nxt(); #1 chk("r5_busy_c5", {31'd0, busy1}, 32'd0);
    chk("r5_we3_off", {31'd0, we3}, 32'd0);

    // Alternating grants from a fresh reset.
    reset = 1; nxt(); reset = 0; chk_a1 = 1; chk_a2 = 8;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1; req0_addr = 5'(a0[k]); req0_data = 32'h100 + 32'(a0[k]);
      req1_valid = 1; req1_addr = 5'(a1[k]); req1_data = 32'h200 + 32'(a1[k]);
      #1;
      chk("alt_ready0", {31'd0, req0_ready}, (gexp[k] == 0) ? 32'd1 : 32'd0);
      chk("alt_ready1", {31'd0, req1_ready}, (gexp[k] == 1) ? 32'd1 : 32'd0);
      if (k > 0) chk("alt_wa3", {27'd0, wa3}, 32'(wexp[k-1]));
      nxt();
    end
    req0_valid = 0; req1_valid = 0; #1;
    chk("alt_wa3_last", {27'd0, wa3}, 32'd9);
    chk("alt_wd3_last", wd3, 32'h209);
    chk("alt_we3_last", {31'd0, we3}, 32'd1);
    nxt();

    // r0 write is consumed but not committed; r0 reservation ignored.
    req1_valid = 1; req1_addr = 0; req1_data = 32'hFFFF; chk_a1 = 0;
    rsv_valid = 1; rsv_addr = 0;
    #1 chk("r0_ready1", {31'd0, req1_ready}, 32'd1);
    nxt(); req1_valid = 0; rsv_valid = 0; #1;
    chk("r0_we3", {31'd0, we3}, 32'd0);
    chk("r0_busy", {31'd0, busy1}, 32'd0);
    chk("r0_err", {31'd0, err}, 32'd0);

    // Reserve r7 on its commit edge, then illegally again.
    rsv_valid = 1; rsv_addr = 7; chk_a1 = 7;
    nxt(); rsv_valid = 0; req0_valid = 1; req0_addr = 7; req0_data = 32'h77;
    #1 chk("r7_ready0", {31'd0, req0_ready}, 32'd1);
    nxt(); req0_valid = 0; #1;
    chk("r7_we3", {31'd0, we3}, 32'd1);
    chk("r7_wa3", {27'd0, wa3}, 32'd7);
    rsv_valid = 1; rsv_addr = 7;
    nxt(); rsv_valid = 0; #1;
    chk("r7_busy_after_same_edge", {31'd0, busy1}, 32'd1);
    chk("r7_err_clear", {31'd0, err}, 32'd0);
    rsv_valid = 1; rsv_addr = 7;
    nxt(); rsv_valid = 0; #1 chk("r7_err_set", {31'd0, err}, 32'd1);
    repeat (3) nxt();
    chk("r7_err_sticky", {31'd0, err}, 32'd1);
    chk("r7_busy_stays", {31'd0, busy1}, 32'd1);

    // Asynchronous reset drops an in-flight write.
    req0_valid = 1; req0_addr = 3; req0_data = 32'h33;
    nxt(); req0_valid = 0; #1;
    chk("async_we3_before", {31'd0, we3}, 32'd1);
    reset = 1; #1;
    chk("async_we3_dropped", {31'd0, we3}, 32'd0);
    chk("async_err_cleared", {31'd0, err}, 32'd0);
    chk("async_busy_cleared", {31'd0, busy1}, 32'd0);
    nxt(); reset = 0;
    repeat (3) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
